// File: rtl/pipo_rr_loader.sv
// Round-robin load controller for a shared PIPO register.
// One requester is captured per grant and held until the consumer acks.
module pipo_rr_loader #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int SW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  input  logic                  po_ack,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      po,
  output logic                  po_valid,
  output logic [SW-1:0]         po_src,
  output logic [7:0]            xfer_cnt
);

  typedef enum logic {
    IDLE,
    VALID
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]  po_q, po_d;
  logic              vld_q, vld_d;
  logic [SW-1:0]     src_q, src_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              found;
  logic [SW-1:0]     win;
  logic [WIDTH-1:0]  win_word;
  int                idx;

  // Search starts at ptr and wraps, so the last winner has lowest priority.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_word = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win      = SW'(idx);
        win_word = din[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    po_d    = po_q;
    vld_d   = vld_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          po_d    = win_word;
          src_d   = win;
          gnt_d   = NREQ'(1) << win;
          vld_d   = 1'b1;
          ptr_d   = (win == SW'(NREQ - 1)) ? '0 : win + SW'(1);
          state_d = VALID;
        end
      end
      VALID: begin
        if (po_ack) begin
          vld_d   = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      po_q    <= '0;
      vld_q   <= 1'b0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      po_q    <= po_d;
      vld_q   <= vld_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign po       = po_q;
  assign po_valid = vld_q;
  assign po_src   = src_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_pipo_rr_loader.sv
// Directed bench for pipo_rr_loader (WIDTH=4, NREQ=4).
// Inputs change and outputs are checked on the falling edge.
module tb_pipo_rr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] din;
  logic        po_ack;
  logic [3:0]  gnt;
  logic [3:0]  po;
  logic        po_valid;
  logic [1:0]  po_src;
  logic [7:0]  xfer_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipo_rr_loader #(.WIDTH(4), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .po_ack(po_ack), .gnt(gnt), .po(po),
    .po_valid(po_valid), .po_src(po_src),
    .xfer_cnt(xfer_cnt)
  );

  task automatic do_reset();
    rst = 1'b1; req = '0; po_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; din = 16'h4321; po_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++;
      if (gnt !== 4'h0 || po_valid !== 1'b0 || po !== 4'h0 ||
          xfer_cnt !== 8'h0 || po_src !== 2'd0) begin
        n_fail++;
        $display("FAIL reset c%0d: gnt=%h vld=%b po=%h src=%0d cnt=%0d want all 0",
                 c, gnt, po_valid, po, po_src, xfer_cnt);
      end
    end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    req = 4'b0100; din = 16'h0A00;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'b0100 || po !== 4'hA || po_src !== 2'd2 || po_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b po=%h src=%0d vld=%b want 0100 a 2 1",
               gnt, po, po_src, po_valid);
    end
    req = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (gnt !== 4'b0 || po !== 4'hA || po_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL single_hold c%0d: gnt=%b po=%h vld=%b want 0000 a 1",
                 c, gnt, po, po_valid);
      end
    end
    po_ack = 1'b1;
    @(negedge clk);
    po_ack = 1'b0;
    n_chk++;
    if (po_valid !== 1'b0 || xfer_cnt !== 8'd1 || po !== 4'hA) begin
      n_fail++;
      $display("FAIL single_ack: vld=%b cnt=%0d po=%h want 0 1 a",
               po_valid, xfer_cnt, po);
    end
  endtask

  task automatic test_round_robin();
    int exp_src[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_po[5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    do_reset();
    req = 4'hF; din = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if (gnt !== (4'b0001 << exp_src[i]) || po !== exp_po[i] ||
          po_src !== 2'(exp_src[i]) || po_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_grant%0d: gnt=%b po=%h src=%0d vld=%b want src %0d po %h",
                 i, gnt, po, po_src, po_valid, exp_src[i], exp_po[i]);
      end
      po_ack = 1'b1;
      if (i == 4) req = '0;
      @(negedge clk);
      po_ack = 1'b0;
      n_chk++;
      if (gnt !== 4'b0 || po_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_gap%0d: gnt=%b vld=%b want 0000 0", i, gnt, po_valid);
      end
    end
    n_chk++;
    if (xfer_cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL rr_count: cnt=%0d want 5", xfer_cnt);
    end
  endtask

  task automatic test_wrap_fairness();
    int alt[4] = '{0, 1, 0, 1};
    do_reset();
    req = 4'b0100; din = 16'h4321;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'b0100 || po !== 4'h3) begin
      n_fail++;
      $display("FAIL wrap_g2: gnt=%b po=%h want 0100 3", gnt, po);
    end
    po_ack = 1'b1; req = 4'b1001;
    @(negedge clk);
    po_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'b1000 || po !== 4'h4 || po_src !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_g3: gnt=%b po=%h src=%0d want 1000 4 3", gnt, po, po_src);
    end
    po_ack = 1'b1;
    @(negedge clk);
    po_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'b0001 || po !== 4'h1 || po_src !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_g0: gnt=%b po=%h src=%0d want 0001 1 0", gnt, po, po_src);
    end
    po_ack = 1'b1; req = '0;
    @(negedge clk);
    po_ack = 1'b0;
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (gnt !== (4'b0001 << alt[i]) || po_src !== 2'(alt[i])) begin
        n_fail++;
        $display("FAIL fair%0d: gnt=%b src=%0d want src %0d", i, gnt, po_src, alt[i]);
      end
      po_ack = 1'b1;
      if (i == 3) req = '0;
      @(negedge clk);
      po_ack = 1'b0;
    end
  endtask

  task automatic test_interference();
    do_reset();
    req = 4'b0001; din = 16'h4321;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'b0001 || po !== 4'h1) begin
      n_fail++;
      $display("FAIL intf_grant: gnt=%b po=%h want 0001 1", gnt, po);
    end
    din = 16'h999F;
    for (int c = 0; c < 3; c++) begin
      req = (c % 2 == 0) ? 4'b1110 : 4'b0001;
      @(negedge clk);
      n_chk++;
      if (po !== 4'h1 || po_src !== 2'd0 || gnt !== 4'b0 || po_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL intf_hold%0d: po=%h src=%0d gnt=%b vld=%b want 1 0 0000 1",
                 c, po, po_src, gnt, po_valid);
      end
    end
    req = '0; po_ack = 1'b1;
    @(negedge clk);
    n_chk++;
    if (po_valid !== 1'b0 || xfer_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL intf_ack: vld=%b cnt=%0d want 0 1", po_valid, xfer_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (xfer_cnt !== 8'd1 || po_valid !== 1'b0 || po !== 4'h1) begin
        n_fail++;
        $display("FAIL idle_ack%0d: cnt=%0d vld=%b po=%h want 1 0 1",
                 c, xfer_cnt, po_valid, po);
      end
    end
    po_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; din = 16'h4321;
    @(negedge clk);
    po_ack = 1'b1; req = '0;
    @(negedge clk);
    po_ack = 1'b0; req = 4'b0010;
    @(negedge clk);
    n_chk++;
    if (po_valid !== 1'b1 || po !== 4'h2 || xfer_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL mid_pre: vld=%b po=%h cnt=%0d want 1 2 1", po_valid, po, xfer_cnt);
    end
    rst = 1'b1; po_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0; po_ack = 1'b0; req = 4'hF;
    n_chk++;
    if (gnt !== 4'b0 || po !== 4'h0 || po_valid !== 1'b0 ||
        po_src !== 2'd0 || xfer_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_rst: gnt=%b po=%h vld=%b src=%0d cnt=%0d want all 0",
               gnt, po, po_valid, po_src, xfer_cnt);
    end
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'b0001 || po_src !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_ptr: gnt=%b src=%0d want 0001 0", gnt, po_src);
    end
    po_ack = 1'b1; req = '0;
    @(negedge clk);
    po_ack = 1'b0;
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    req = 4'b0001; din = 16'h4321;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      po_ack = 1'b1;
      @(negedge clk);
      po_ack = 1'b0;
    end
    n_chk++;
    if (xfer_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL cnt_255: cnt=%0d want 255", xfer_cnt);
    end
    @(negedge clk);
    po_ack = 1'b1; req = '0;
    @(negedge clk);
    po_ack = 1'b0;
    n_chk++;
    if (xfer_cnt !== 8'd0 || po_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_wrap: cnt=%0d vld=%b want 0 0", xfer_cnt, po_valid);
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; din = '0; po_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_fairness();
    test_interference();
    test_reset_mid();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
